line_burst_adapter: RTL and testbench

//   Converts one 256-bit cache-line request from the L1 arbiter's L2-side port into a

---
 rtl/line_burst_adapter.sv | 135 +++++++++++++
 tb/tb_line_burst_adapter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adapter.sv
// rtl/line_burst_adapter.sv - cache-line to 64-bit memory burst adapter
// One line request becomes a 4-beat read (assembled) or write (serialised) burst.
module line_burst_adapter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int OFF_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] line_addr_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [BEAT_W-1:0] mem_wdata_o,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_RECOV} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [BEAT_W-1:0]   wdata_q, wdata_d;
    logic                resp_q, resp_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   aligned_addr;
    logic                last_beat;
    logic                unused_off;

    assign aligned_addr = {line_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign last_beat    = (cnt_q == CNT_W'(BEATS - 1));
    assign unused_off   = ^line_addr_i[OFF_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        resp_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (line_write_i) begin
                    addr_d  = aligned_addr;
                    buf_d   = line_wdata_i;
                    wdata_d = line_wdata_i[BEAT_W-1:0];
                    wr_d    = 1'b1;
                    state_d = S_WR;
                end else if (line_read_i) begin
                    addr_d  = aligned_addr;
                    rd_d    = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (mem_resp_i) begin
                    rdata_d[BEAT_W*int'(cnt_q) +: BEAT_W] = mem_rdata_i;
                    if (last_beat) begin
                        cnt_d   = '0;
                        rd_d    = 1'b0;
                        resp_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WR: begin
                // The buffer shifts down one beat per accept, so beat 0 is always the low slice.
                if (mem_resp_i) begin
                    buf_d = buf_q >> BEAT_W;
                    if (last_beat) begin
                        cnt_d   = '0;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        resp_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        wdata_d = buf_q[2*BEAT_W-1:BEAT_W];
                    end
                end
            end
            S_DONE:  state_d = S_RECOV;
            S_RECOV: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign line_rdata_o = rdata_q;
    assign line_resp_o  = resp_q;
    assign mem_addr_o   = addr_q;
    assign mem_read_o   = rd_q;
    assign mem_write_o  = wr_q;
    assign mem_wdata_o  = wdata_q;
endmodule

// File: tb/tb_line_burst_adapter.sv
// tb/tb_line_burst_adapter.sv - self-checking bench for line_burst_adapter
module tb_line_burst_adapter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  line_addr = '0;
    logic [255:0] line_wdata = '0;
    logic         line_read = 1'b0;
    logic         line_write = 1'b0;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    line_burst_adapter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .line_addr_i(line_addr), .line_wdata_i(line_wdata),
        .line_read_i(line_read), .line_write_i(line_write),
        .line_rdata_o(line_rdata), .line_resp_o(line_resp),
        .mem_addr_o(mem_addr), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rd;
        logic         wr;
        logic         drop;
        logic [3:0]   gap;
        logic [7:0]   lat;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] wdata;
        logic [255:0] rbeats;
    } vec_t;

    vec_t         tbl [5];
    logic [255:0] rq [$];
    logic [63:0]  wq [$];
    logic [255:0] last_rdata = '0;
    logic [255:0] rb = '0;
    logic [31:0]  exp_addr = '0;
    int           gap = 0;
    int           rd_cycles = 0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Memory model: one mem_resp after every `gap` idle cycles while a burst is active.
    int wcnt = 0;
    int bidx = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n || !(mem_read || mem_write)) begin
            mem_resp = 1'b0;
            wcnt = 0;
            bidx = 0;
        end else if (wcnt >= gap) begin
            mem_resp  = 1'b1;
            mem_rdata = rb[(bidx % 4)*64 +: 64];
            bidx++;
            wcnt = 0;
        end else begin
            mem_resp = 1'b0;
            wcnt++;
        end
    end

    // Scoreboard monitor: write beats and completions are popped as the DUT produces them.
    always @(negedge clk) begin
        if (mem_read) rd_cycles++;
        if (mem_read && mem_write) chk("rd_wr_both", 1, 0);
        if (mem_read || mem_write) chk("mem_addr", mem_addr, exp_addr);
        if (mem_write) begin
            if (wq.size() == 0) chk("wbeat_unexpected", 1, 0);
            else begin
                chk("mem_wdata", mem_wdata, wq[0]);
                if (mem_resp) void'(wq.pop_front());
            end
        end
        if (line_resp) begin
            if (rq.size() == 0) chk("resp_unexpected", 1, 0);
            else chk("line_rdata", line_rdata, rq.pop_front());
        end
    end

    task automatic wait_resp(output int n, output logic got);
        n = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            if (line_resp) got = 1'b1;
        end
        chk("resp_timeout", got, 1);
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        int rd0;
        logic got;
        gap = int'(v.gap);
        rb = v.rbeats;
        exp_addr = v.exp_addr;
        if (v.wr) begin
            for (int i = 0; i < 4; i++) wq.push_back(v.wdata[i*64 +: 64]);
            rq.push_back(last_rdata);
        end else begin
            last_rdata = v.rbeats;
            rq.push_back(v.rbeats);
        end
        @(posedge clk); #1;
        rd0 = rd_cycles;
        line_addr = v.addr;
        line_wdata = v.wdata;
        line_read = v.rd;
        line_write = v.wr;
        n = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                line_addr = ~v.addr;
                line_wdata = ~v.wdata;
                if (v.drop) begin
                    line_read = 1'b0;
                    line_write = 1'b0;
                end
            end
            if (line_resp) got = 1'b1;
        end
        chk("resp_seen", got, 1);
        chk("latency", n, v.lat);
        chk("rd_cycles", rd_cycles - rd0, v.wr ? 0 : 4 * int'(v.gap) + 4);
        line_read = 1'b0;
        line_write = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n;
        int rd0;
        logic got;
        vec_t v;
        tbl[0] = '{rd:1'b1, wr:1'b0, drop:1'b0, gap:4'd0, lat:8'd6, addr:32'h0000_1234, exp_addr:32'h0000_1220,
                   wdata:'0, rbeats:{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        tbl[1] = '{rd:1'b0, wr:1'b1, drop:1'b0, gap:4'd3, lat:8'd18, addr:32'h0000_567F, exp_addr:32'h0000_5660,
                   wdata:{64'hD3D3_0003_0000_0033, 64'hD2D2_0002_0000_0022,
                          64'hD1D1_0001_0000_0011, 64'hD0D0_0000_0000_0000}, rbeats:'0};
        tbl[2] = '{rd:1'b1, wr:1'b1, drop:1'b0, gap:4'd0, lat:8'd6, addr:32'h0000_0040, exp_addr:32'h0000_0040,
                   wdata:{64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
                          64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001}, rbeats:'0};
        tbl[3] = '{rd:1'b1, wr:1'b0, drop:1'b1, gap:4'd1, lat:8'd10, addr:32'hDEAD_BEEF, exp_addr:32'hDEAD_BEE0,
                   wdata:'0, rbeats:{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                     64'h8000_0000_0000_0001, 64'h5A5A_A5A5_5A5A_A5A5}};
        tbl[4] = '{rd:1'b0, wr:1'b1, drop:1'b1, gap:4'd0, lat:8'd6, addr:32'hFFFF_FFFF, exp_addr:32'hFFFF_FFE0,
                   wdata:{64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                          64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF}, rbeats:'0};

        #12;
        chk("rst_line_rdata", line_rdata, '0);
        chk("rst_line_resp", line_resp, 0);
        chk("rst_mem", {mem_addr, mem_read, mem_write, mem_wdata}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) do_txn(tbl[i]);

        // Request held through RECOV must not start a second burst.
        v = tbl[0];
        gap = 0;
        rb = v.rbeats;
        exp_addr = v.exp_addr;
        last_rdata = v.rbeats;
        rq.push_back(v.rbeats);
        @(posedge clk); #1;
        line_addr = v.addr;
        line_read = 1'b1;
        wait_resp(n, got);
        @(posedge clk);
        @(posedge clk); #1;
        line_read = 1'b0;
        rd0 = rd_cycles;
        repeat (6) @(negedge clk);
        chk("held_no_reburst", rd_cycles - rd0, 0);

        // Request held continuously: next burst starts at T8 after resp at T5.
        rq.push_back(v.rbeats);
        @(posedge clk); #1;
        line_read = 1'b1;
        wait_resp(n, got);
        rq.push_back(v.rbeats);
        @(negedge clk);
        chk("t6_mem_read", mem_read, 0);
        @(negedge clk);
        chk("t7_mem_read", mem_read, 0);
        @(negedge clk);
        chk("t8_mem_read", mem_read, 1);
        wait_resp(n, got);
        line_read = 1'b0;
        repeat (2) @(posedge clk);

        // Async reset mid-read after two beats: everything clears, no completion.
        v = tbl[3];
        gap = 0;
        rb = v.rbeats;
        exp_addr = v.exp_addr;
        @(posedge clk); #1;
        line_addr = v.addr;
        line_read = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_line_rdata", line_rdata, '0);
        chk("arst_line_resp", line_resp, 0);
        chk("arst_mem", {mem_addr, mem_read, mem_write, mem_wdata}, '0);
        rq.delete();
        wq.delete();
        last_rdata = '0;
        line_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        v.drop = 1'b0;
        v.gap = 4'd0;
        v.lat = 8'd6;
        v.rbeats = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                    64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
        do_txn(v);
        chk("queues_drained", rq.size() + wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
